// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a first-word fall-through FIFO into a valid/ready stream through a
// two-entry (head + skid) output buffer, so the FIFO pop strobe never depends
// combinationally on the downstream ready.
// Optional packet framing: define FIFO_STREAM_READER_TLAST_EN to count
// accepted beats and raise m_tlast_o on every BURST_LEN-th beat; without it
// m_tlast_o is tied low and no counter exists.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk_i,
  input  logic                  s_rst_i,
  input  logic                  enable_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tlast_o
);

  // Buffer occupancy: number of words held between the FIFO and the stream.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Reject illegal configurations at elaboration time.
  if (DATA_WIDTH < 1 || BURST_LEN < 1 || BURST_LEN > 65535) begin : g_param_check
    $error("fifo_stream_reader: DATA_WIDTH must be >= 1 and BURST_LEN in 1..65535");
  end

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  pop;
  logic                  accept;

  // Pop only when a word is available and there is room to store it; the
  // room test uses registered state alone, never m_tready_i.
  assign pop    = ~fifo_empty_i & enable_i & (state_q != ST_TWO) & ~s_rst_i;
  assign accept = m_tvalid_o & m_tready_i;

  assign fifo_rd_en_o = pop;
  assign m_tvalid_o   = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign m_tdata_o    = head_q;

  // Next occupancy and buffer contents from the pop/accept pair.
  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (pop) begin
          head_d  = fifo_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (pop && accept) begin
          // Head leaves and the new word takes its place.
          head_d = fifo_data_i;
        end else if (pop) begin
          skid_d  = fifo_data_i;
          state_d = ST_TWO;
        end else if (accept) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // No pop is possible here, so only acceptance moves things.
        if (accept) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Occupancy register; reset empties the buffer, discarding held words.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Data storage for head and skid entries.
  // NOTE: the data registers are deliberately not reset; their contents are
  // meaningless whenever the occupancy says they are empty.
  always_ff @(posedge clk_i) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

`ifdef FIFO_STREAM_READER_TLAST_EN
  localparam logic [15:0] LAST_CNT = 16'(BURST_LEN - 1);

  logic [15:0] beat_cnt_q, beat_cnt_d;

  // Count accepted beats, wrapping after the last beat of a packet.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      beat_cnt_d = (beat_cnt_q == LAST_CNT) ? 16'd0 : beat_cnt_q + 16'd1;
    end
  end

  // Beat counter register; reset restarts the packet at beat 1.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Counter only moves on acceptance, so tlast is stable during stalls.
  assign m_tlast_o = m_tvalid_o && (beat_cnt_q == LAST_CNT);
`else
  assign m_tlast_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. A queue models the FWFT FIFO;
// every pushed word also goes to a scoreboard queue and is compared when the
// stream accepts a beat. Define FIFO_STREAM_READER_TLAST_EN for both files to
// check packet framing with BURST_LEN = 4.
module tb_fifo_stream_reader;

  localparam int DW    = 32;
  localparam int BURST = 4;
`ifdef FIFO_STREAM_READER_TLAST_EN
  localparam bit TLAST_ON = 1'b1;
`else
  localparam bit TLAST_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          s_rst_i = 1'b1;
  logic          enable_i = 1'b1;
  logic          fifo_rd_en_o;
  logic [DW-1:0] fifo_data_i = '0;
  logic          fifo_empty_i = 1'b1;
  logic          m_tvalid_o;
  logic          m_tready_i = 1'b0;
  logic [DW-1:0] m_tdata_o;
  logic          m_tlast_o;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BURST)) dut (
    .clk_i       (clk),
    .s_rst_i     (s_rst_i),
    .enable_i    (enable_i),
    .fifo_rd_en_o(fifo_rd_en_o),
    .fifo_data_i (fifo_data_i),
    .fifo_empty_i(fifo_empty_i),
    .m_tvalid_o  (m_tvalid_o),
    .m_tready_i  (m_tready_i),
    .m_tdata_o   (m_tdata_o),
    .m_tlast_o   (m_tlast_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_pass = 0;
  int            n_total = 0;
  int            in_flight = 0;
  int            tb_cnt = 0;
  int            n_last_seen = 0;
  int            beats_since_rst = 0;
  int            first_last_beat = 0;
  logic [DW-1:0] first_data = '0;
  bit            first_seen = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic          s_rd_en, s_valid, s_last;
  logic [DW-1:0] s_data;

  task automatic update_fifo();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = fifo_empty_i ? 32'hDEAD_BEEF : fifo_q[0];
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    update_fifo();
  endtask

  // One clock cycle: sample outputs at the falling edge, score accepted
  // beats, then apply the FIFO pop just after the rising edge.
  task automatic cycle();
    logic          do_pop, do_acc, rst_now, exp_last;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    rst_now = s_rst_i;
    s_rd_en = fifo_rd_en_o;
    s_valid = m_tvalid_o;
    s_data  = m_tdata_o;
    s_last  = m_tlast_o;
    do_pop  = (fifo_rd_en_o === 1'b1);
    do_acc  = (m_tvalid_o === 1'b1) && m_tready_i && !rst_now;

    n_total++;
    if (do_pop && (fifo_empty_i || !enable_i || rst_now))
      $display("FAIL rd_en_guard: rd_en=%b while empty=%b enable=%b rst=%b",
               fifo_rd_en_o, fifo_empty_i, enable_i, rst_now);
    else n_pass++;

    if (prev_stall && !rst_now) begin
      n_total++;
      if (m_tvalid_o !== 1'b1 || m_tdata_o !== prev_data || m_tlast_o !== prev_last)
        $display("FAIL stall_stable: valid=%b data=%h last=%b, need 1/%h/%b",
                 m_tvalid_o, m_tdata_o, m_tlast_o, prev_data, prev_last);
      else n_pass++;
    end

    if (do_acc) begin
      exp_last = TLAST_ON && (tb_cnt == BURST - 1);
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL beat_extra: data=%h accepted with empty scoreboard", m_tdata_o);
      end else begin
        exp_d = exp_q.pop_front();
        if (m_tdata_o !== exp_d || m_tlast_o !== exp_last)
          $display("FAIL beat_data: data=%h last=%b, need %h/%b",
                   m_tdata_o, m_tlast_o, exp_d, exp_last);
        else n_pass++;
      end
      tb_cnt = (tb_cnt == BURST - 1) ? 0 : tb_cnt + 1;
      beats_since_rst++;
      if (m_tlast_o === 1'b1) begin
        n_last_seen++;
        if (first_last_beat == 0) first_last_beat = beats_since_rst;
      end
      if (!first_seen) begin
        first_seen = 1'b1;
        first_data = m_tdata_o;
      end
    end

    prev_stall = (m_tvalid_o === 1'b1) && !m_tready_i && !rst_now;
    prev_data  = m_tdata_o;
    prev_last  = m_tlast_o;

    @(posedge clk);
    #1;
    if (rst_now) begin
      // Buffered words are discarded: drop them from the scoreboard too.
      for (int i = 0; i < in_flight; i++) void'(exp_q.pop_front());
      in_flight       = 0;
      tb_cnt          = 0;
      beats_since_rst = 0;
      first_last_beat = 0;
      first_seen      = 1'b0;
      prev_stall      = 1'b0;
    end else begin
      if (do_pop) begin
        void'(fifo_q.pop_front());
        in_flight++;
      end
      if (do_acc) in_flight--;
    end
    update_fifo();
  endtask

  task automatic do_reset();
    s_rst_i    = 1'b1;
    m_tready_i = 1'b0;
    cycle();
    s_rst_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    m_tready_i = 1'b1;
    enable_i   = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      cycle();
      n++;
    end
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: %0d words still expected after %0d cycles", name, exp_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    s_rst_i = 1'b1;
    push_word(32'h0000_00C1);
    push_word(32'h0000_00C2);
    cycle();
    n_total++;
    if (s_rd_en !== 1'b0) $display("FAIL reset_rd_en: rd_en=%b, need 0", s_rd_en);
    else n_pass++;
    cycle();
    n_total++;
    if (s_valid !== 1'b0 || s_last !== 1'b0 || s_rd_en !== 1'b0)
      $display("FAIL reset_state: valid=%b last=%b rd_en=%b, need 0/0/0", s_valid, s_last, s_rd_en);
    else n_pass++;
    s_rst_i = 1'b0;
    cycle();
    n_total++;
    if (s_valid !== 1'b0 || s_rd_en !== 1'b1)
      $display("FAIL reset_release: valid=%b rd_en=%b, need 0/1", s_valid, s_rd_en);
    else n_pass++;
    drain("reset");
  endtask

  task automatic test_preload();
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    m_tready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_total++;
      if (s_rd_en !== (i < 8) || s_valid !== (i >= 1 && i <= 8))
        $display("FAIL preload_c%0d: rd_en=%b valid=%b, need %b/%b",
                 i, s_rd_en, s_valid, (i < 8), (i >= 1 && i <= 8));
      else n_pass++;
      if (i >= 1 && i <= 8) begin
        n_total++;
        if (s_data !== DW'(i)) $display("FAIL preload_data%0d: data=%h, need %h", i, s_data, DW'(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) push_word(32'hB000_0000 + DW'(i));
    m_tready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_total++;
      if (s_rd_en !== (i < 2)) $display("FAIL bp_rd_en%0d: rd_en=%b, need %b", i, s_rd_en, (i < 2));
      else n_pass++;
      if (i >= 1) begin
        n_total++;
        if (s_valid !== 1'b1 || s_data !== 32'hB000_0000)
          $display("FAIL bp_hold%0d: valid=%b data=%h, need 1/b0000000", i, s_valid, s_data);
        else n_pass++;
      end
    end
    drain("bp");
  endtask

  task automatic test_random();
    int pushed = 0;
    int n = 0;
    do_reset();
    while ((pushed < 1000 || exp_q.size() != 0) && n < 20000) begin
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        push_word($urandom);
        pushed++;
      end
      m_tready_i = 1'($urandom_range(0, 1));
      enable_i   = ($urandom_range(0, 7) != 0);
      cycle();
      n++;
    end
    enable_i = 1'b1;
    n_total++;
    if (pushed != 1000 || exp_q.size() != 0)
      $display("FAIL random_done: pushed=%0d left=%0d, need 1000/0", pushed, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_tlast();
    int base;
    do_reset();
    base = n_last_seen;
    for (int i = 0; i < 12; i++) push_word(32'h7000_0000 + DW'(i));
    drain("tlast");
    n_total++;
    if (n_last_seen - base != (TLAST_ON ? 3 : 0))
      $display("FAIL tlast_count: saw %0d, need %0d", n_last_seen - base, (TLAST_ON ? 3 : 0));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) push_word(32'hA000_0000 + DW'(i));
    m_tready_i = 1'b0;
    cycle();
    cycle();
    m_tready_i = 1'b1;
    cycle();
    cycle();
    m_tready_i = 1'b0;
    cycle();
    n_total++;
    if (in_flight != 2 || beats_since_rst != 2)
      $display("FAIL midrst_setup: buffered=%0d beats=%0d, need 2/2", in_flight, beats_since_rst);
    else n_pass++;
    do_reset();
    cycle();
    n_total++;
    if (s_valid !== 1'b0) $display("FAIL midrst_valid: valid=%b, need 0", s_valid);
    else n_pass++;
    for (int i = 0; i < 3; i++) push_word(32'hA100_0000 + DW'(i));
    drain("midrst");
    n_total++;
    if (first_data !== 32'hA000_0004)
      $display("FAIL midrst_first: data=%h, need a0000004", first_data);
    else n_pass++;
    n_total++;
    if (first_last_beat != (TLAST_ON ? 4 : 0))
      $display("FAIL midrst_tlast: first tlast on beat %0d, need %0d", first_last_beat, (TLAST_ON ? 4 : 0));
    else n_pass++;
  endtask

  initial begin
    update_fifo();
    test_reset();
    test_preload();
    test_backpressure();
    test_random();
    test_tlast();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
